// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The optional round-robin tie-break is selected with MEM_ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

    // Arbiter FSM encoding (2 bits).
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    // Memory-side control levels.
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // True while a memory access is in flight.
    function automatic logic is_busy(input arb_state_e s);
        return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the memory arbiter: counts cycles spent waiting on the memory
// and flags expiry in the cycle where the count reaches TimeoutCycles-1.
module mem_arb_wdog #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] LastCount = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up while enabled (holds at the limit).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LastCount)) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == LastCount);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// Memory-side signals, acks and read data are all registered. state_q is the
// FSM debug tap. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// without it the data port always wins a tie.
//
// Handshake: a requester raises x_req_i with its command and holds both until
// it sees the one-cycle x_ack_o pulse; x_rdata_o (and err_o) are valid in that
// ack cycle. The arbiter never samples requests during an ack cycle, so a
// request still high then is not mistaken for a new one.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_i,
    input  logic [AddrWidth-1:0]   i_addr_i,
    output logic                   i_ack_o,
    output logic [DataWidth-1:0]   i_rdata_o,
    input  logic                   d_req_i,
    input  logic                   d_we_i,
    input  logic [AddrWidth-1:0]   d_addr_i,
    input  logic [DataWidth/8-1:0] d_sel_i,
    input  logic [DataWidth-1:0]   d_wdata_i,
    output logic                   d_ack_o,
    output logic [DataWidth-1:0]   d_rdata_o,
    output logic                   err_o,
    output logic                   stallreq_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth/8-1:0] mem_sel_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_ack_i
);
    localparam int SelWidth = DataWidth / 8;

    arb_state_e           state_q, state_d;
    logic                 mem_ce_q, mem_ce_d;
    logic                 mem_we_q, mem_we_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [SelWidth-1:0]  mem_sel_q, mem_sel_d;
    logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic [DataWidth-1:0] i_rdata_q, i_rdata_d;
    logic [DataWidth-1:0] d_rdata_q, d_rdata_d;
    logic                 err_q, err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                 last_data_q, last_data_d;
`endif

    logic sample_en;
    logic pick_data;
    logic pick_inst;
    logic wdog_expired;

    // Grant selection in IDLE; requests are ignored during an ack cycle.
    always_comb begin
        sample_en = !i_ack_q && !d_ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (d_req_i && i_req_i) begin
            pick_data = !last_data_q;
            pick_inst = last_data_q;
        end else begin
            pick_data = d_req_i;
            pick_inst = i_req_i;
        end
`else
        pick_data = d_req_i;
        pick_inst = i_req_i && !d_req_i;
`endif
    end

    // FSM next state and registered datapath updates.
    always_comb begin
        state_d     = state_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (sample_en && pick_data) begin
                    state_d     = ARB_BUSY_D;
                    mem_ce_d    = CHIP_ENABLE;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_sel_d   = d_sel_i;
                    mem_wdata_d = d_wdata_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b1;
`endif
                end else if (sample_en && pick_inst) begin
                    state_d    = ARB_BUSY_I;
                    mem_ce_d   = CHIP_ENABLE;
                    mem_we_d   = WRITE_DISABLE;
                    mem_addr_d = i_addr_i;
                    mem_sel_d  = {SelWidth{1'b1}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b0;
`endif
                end
            end
            ARB_BUSY_I: begin
                if (mem_ack_i || wdog_expired) begin
                    // A real ack beats an expiry landing in the same cycle.
                    i_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    err_d     = !mem_ack_i;
                    i_ack_d   = 1'b1;
                    mem_ce_d  = CHIP_DISABLE;
                    mem_we_d  = WRITE_DISABLE;
                    state_d   = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (mem_ack_i) begin
                    // Stores leave the last load result in place.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                    d_ack_d  = 1'b1;
                    mem_ce_d = CHIP_DISABLE;
                    mem_we_d = WRITE_DISABLE;
                    state_d  = ARB_IDLE;
                end else if (wdog_expired) begin
                    d_rdata_d = '0;
                    err_d     = 1'b1;
                    d_ack_d   = 1'b1;
                    mem_ce_d  = CHIP_DISABLE;
                    mem_we_d  = WRITE_DISABLE;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                mem_ce_d = CHIP_DISABLE;
                mem_we_d = WRITE_DISABLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    mem_arb_wdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!is_busy(state_q)),
        .en_i     (is_busy(state_q)),
        .expired_o(wdog_expired)
    );

    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_wdata_o = mem_wdata_q;
    assign i_ack_o     = i_ack_q;
    assign d_ack_o     = d_ack_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign stallreq_o  = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written multi-cycle
// sequences (ties, stray ack, reset mid-access) and a randomized phase checked
// against a word-level memory reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic          i_ack_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [SW-1:0] d_sel_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          err_o;
  logic          stallreq_o;
  logic          mem_ce_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [SW-1:0] mem_sel_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .err_o(err_o), .stallreq_o(stallreq_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Device memory (driven to the DUT) and reference memory (expectations).
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [31:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endfunction

  // The access on the memory bus must be exactly one pending requester's command.
  function automatic logic access_legal();
    logic d_ok, i_ok;
    d_ok = d_req_i && (mem_we_o == d_we_i) && (mem_addr_o == d_addr_i) &&
           (mem_sel_o == d_sel_i) && (!d_we_i || (mem_wdata_o == d_wdata_i));
    i_ok = i_req_i && !mem_we_o && (mem_addr_o == i_addr_i) && (mem_sel_o == 4'hF);
    return d_ok || i_ok;
  endfunction

  // ---------------- memory model ----------------
  int mem_wait  = 0;    // directed wait states; negative = never acknowledge
  bit mem_rand  = 1'b0; // random 0..4 wait states
  bit stray_ack = 1'b0; // inject an unsolicited ack
  int mem_cyc   = 0;
  int cur_wait  = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      if (mem_ce_o === 1'b1) begin
        if (mem_cyc == 0) begin
          cur_wait = mem_rand ? int'($urandom_range(0, 4)) : mem_wait;
          check("mem_access_legal", 32'(access_legal()), 32'd1);
        end
        if (mem_cyc == cur_wait) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = dev_read(mem_addr_o);
          if (mem_we_o) mem_arr[mem_addr_o] = merge(dev_read(mem_addr_o), mem_wdata_o, mem_sel_o);
        end
        mem_cyc++;
      end else begin
        mem_cyc = 0;
      end
      if (stray_ack) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
      end
    end
  end

  // ---------------- continuous monitor ----------------
  bit mon_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("stallreq", 32'(stallreq_o), 32'((i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o)));
        check("ack_exclusive", 32'(i_ack_o & d_ack_o), 32'd0);
        check("err_only_with_ack", 32'(err_o & ~(i_ack_o | d_ack_o)), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    stray_ack = 1'b0; mem_rand = 1'b0; mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_ce"},    32'(mem_ce_o),    32'd0);
    check({tag, "_mem_we"},    32'(mem_we_o),    32'd0);
    check({tag, "_mem_addr"},  mem_addr_o,       32'd0);
    check({tag, "_mem_sel"},   32'(mem_sel_o),   32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o,      32'd0);
    check({tag, "_i_ack"},     32'(i_ack_o),     32'd0);
    check({tag, "_d_ack"},     32'(d_ack_o),     32'd0);
    check({tag, "_i_rdata"},   i_rdata_o,        32'd0);
    check({tag, "_d_rdata"},   d_rdata_o,        32'd0);
    check({tag, "_err"},       32'(err_o),       32'd0);
    check({tag, "_state"},     32'(dut.state_q), 32'(ARB_IDLE));
  endtask

  task automatic i_access(input logic [31:0] addr, output logic [31:0] data, output logic err);
    bit got;
    got = 1'b0;
    i_addr_i = addr;
    i_req_i  = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (i_ack_o) got = 1'b1;
    end
    data = i_rdata_o;
    err  = err_o;
    i_req_i = 1'b0;
    if (!got) check("i_ack_wait", 32'd0, 32'd1);
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, output logic [31:0] data, output logic err);
    bit got;
    got = 1'b0;
    d_we_i = we; d_addr_i = addr; d_sel_i = sel; d_wdata_i = wdata;
    d_req_i = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (d_ack_o) got = 1'b1;
    end
    data = d_rdata_o;
    err  = err_o;
    d_req_i = 1'b0;
    if (!got) check("d_ack_wait", 32'd0, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          waits;     // memory wait states, negative = no ack
    int          exp_lat;   // edges from request until ack visible
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int lat, hold, stall_bad;
    logic exp_we, ack;
    logic [31:0] data;
    string p;
    p = $sformatf("v%0d", idx);
    exp_we = v.is_d & v.we;
    mem_wait = v.waits;
    if (v.is_d) begin
      d_we_i = v.we; d_addr_i = v.addr; d_sel_i = v.sel; d_wdata_i = v.wdata; d_req_i = 1'b1;
    end else begin
      i_addr_i = v.addr; i_req_i = 1'b1;
    end
    lat = 0; hold = 0; stall_bad = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      step();
      ack = v.is_d ? d_ack_o : i_ack_o;
      if (ack) begin
        lat = k;
      end else begin
        if (mem_ce_o && (mem_we_o == exp_we) && (mem_addr_o == v.addr) && (mem_sel_o == v.sel) &&
            (!exp_we || (mem_wdata_o == v.wdata))) hold++;
        if (!stallreq_o) stall_bad++;
      end
    end
    data = v.is_d ? d_rdata_o : i_rdata_o;
    check({p, "_latency"},    32'(lat), 32'(v.exp_lat));
    check({p, "_mem_hold"},   32'(hold), 32'(v.exp_lat - 1));
    check({p, "_stall_wait"}, 32'(stall_bad), 32'd0);
    check({p, "_rdata"},      data, v.exp_rdata);
    check({p, "_err"},        32'(err_o), 32'(v.exp_err));
    check({p, "_other_ack"},  32'(v.is_d ? i_ack_o : d_ack_o), 32'd0);
    check({p, "_stall_ack"},  32'(stallreq_o), 32'd0);
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    step();
    check({p, "_ack_pulse"},  32'({err_o, i_ack_o, d_ack_o}), 32'd0);
    step();
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] last_load;

  initial begin
    int order[$];
    int exp_order[4];
    bit first_is_d;
    int bad;

    for (int a = 0; a < 64; a++) preload(32'(a * 4), $urandom);
    for (int a = 0; a < 16; a++) preload(32'h400 + 32'(a * 4), $urandom);
    preload(32'h0000_0004, 32'h3401_1100);
    preload(32'h0000_0008, 32'hCAFE_F00D);
    mem_arr[32'h200] = 32'h0BAD_F00D;
    mem_arr[32'h100] = 32'h1122_3344;

    //           is_d we  addr     sel   wdata          waits lat rdata          err
    vecs[0] = '{1'b0, 1'b0, 32'h004, 4'hF, 32'h0,          0,  2, 32'h3401_1100, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h200, 4'hF, 32'h0,          1,  3, 32'h0BAD_F00D, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h100, 4'h3, 32'hDEAD_BEEF,  3,  5, 32'h0BAD_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h100, 4'hF, 32'h0,          0,  2, 32'h1122_BEEF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h008, 4'hF, 32'h0,         15, 17, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h00C, 4'hF, 32'h0,         -1, 17, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h200, 4'hF, 32'h0,         -1, 17, 32'h0,         1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h200, 4'hF, 32'h0,          2,  4, 32'h0BAD_F00D, 1'b0};

    do_reset();
    mon_en = 1'b1;
    check_all_zero("reset");
    check("reset_stallreq", 32'(stallreq_o), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Unsolicited memory acks while idle must be ignored.
    bad = 0;
    stray_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) stray_ack = 1'b0;
      step();
      if (i_ack_o || d_ack_o || err_o || mem_ce_o) bad++;
    end
    check("stray_ack_ignored", 32'(bad), 32'd0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_is_d = 1'b0;
    exp_order  = '{0, 1, 0, 1};
`else
    first_is_d = 1'b1;
    exp_order  = '{1, 1, 1, 1};
`endif

    // Simultaneous requests: first grant, ack, turnaround, second grant.
    do_reset();
    mem_wait = 0;
    d_we_i = 1'b0; d_addr_i = 32'h200; d_sel_i = 4'hF; d_req_i = 1'b1;
    i_addr_i = 32'h004; i_req_i = 1'b1;
    step();
    check("tie_first_addr", mem_addr_o, first_is_d ? 32'h200 : 32'h004);
    step();
    check("tie_first_ack", 32'({d_ack_o, i_ack_o}), first_is_d ? 32'd2 : 32'd1);
    if (first_is_d) d_req_i = 1'b0; else i_req_i = 1'b0;
    step();
    check("tie_turnaround", 32'({mem_ce_o, d_ack_o, i_ack_o}), 32'd0);
    step();
    check("tie_second_ce", 32'(mem_ce_o), 32'd1);
    check("tie_second_addr", mem_addr_o, first_is_d ? 32'h004 : 32'h200);
    step();
    check("tie_second_ack", 32'({d_ack_o, i_ack_o}), first_is_d ? 32'd1 : 32'd2);
    check("tie_second_rdata", first_is_d ? i_rdata_o : d_rdata_o,
          first_is_d ? 32'h3401_1100 : 32'h0BAD_F00D);
    i_req_i = 1'b0; d_req_i = 1'b0;
    step(); step();

    // Continuous ties: both requesters keep requesting.
    do_reset();
    mem_wait = 0;
    d_we_i = 1'b0; d_addr_i = 32'h200; d_sel_i = 4'hF; d_req_i = 1'b1;
    i_addr_i = 32'h004; i_req_i = 1'b1;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      step();
      if (d_ack_o) order.push_back(1);
      if (i_ack_o) order.push_back(0);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    check("ties_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check($sformatf("ties_grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
    step(); step();

    // Reset in the middle of a fetch that the memory never answers.
    mem_wait = -1;
    i_addr_i = 32'h010; i_req_i = 1'b1;
    step(); step(); step();
    check("midrst_busy_state", 32'(dut.state_q), 32'(ARB_BUSY_I));
    rst = 1'b1; i_req_i = 1'b0;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (i_ack_o || d_ack_o || err_o) bad++;
    end
    check("midrst_no_ack", 32'(bad), 32'd0);

    // Randomized concurrent traffic against the reference memory.
    do_reset();
    mem_rand = 1'b1;
    last_load = 32'h0;
    fork
      begin
        logic [31:0] a, data;
        logic err;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) step();
          a = 32'($urandom_range(0, 63)) << 2;
          i_access(a, data, err);
          check("rand_fetch_data", data, ref_mem[a]);
          check("rand_fetch_err", 32'(err), 32'd0);
        end
      end
      begin
        logic [31:0] a, wd, data;
        logic [3:0] sel;
        logic we, err;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) step();
          we  = 1'($urandom_range(0, 1));
          a   = 32'h400 + (32'($urandom_range(0, 15)) << 2);
          sel = 4'($urandom_range(1, 15));
          wd  = $urandom;
          d_access(we, a, sel, wd, data, err);
          if (we) begin
            ref_mem[a] = merge(ref_mem[a], wd, sel);
            check("rand_store_keeps_rdata", data, last_load);
          end else begin
            check("rand_load_data", data, ref_mem[a]);
            last_load = ref_mem[a];
          end
          check("rand_data_err", 32'(err), 32'd0);
        end
      end
    join
    step(); step();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
